// File: rtl/hazard3_ahbl_pkg.sv
// AHB-Lite encodings and small helpers shared by the bus arbiter slice.
package hazard3_ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NSEQ   = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DATA    = 4'b0011;
  localparam logic [3:0] HPROT_INSTR   = 4'b0010;

  // A one-port arbiter still needs a 1-bit pointer so the port lists stay legal.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hazard3_bus_arbiter_if.sv
// Requester-side split-phase handshake plus the shared AHB-Lite master port.
interface hazard3_bus_arbiter_if #(
  parameter int N_PORTS = 2,
  parameter int W_ADDR  = 32,
  parameter int W_DATA  = 32
);
  logic [N_PORTS-1:0]        req_aph_req;
  logic [N_PORTS-1:0]        req_aph_urgent;
  logic [N_PORTS-1:0]        req_aph_ready;
  logic [N_PORTS-1:0]        req_dph_ready;
  logic [N_PORTS-1:0]        req_dph_err;
  logic [N_PORTS*W_ADDR-1:0] req_haddr;
  logic [N_PORTS-1:0]        req_hwrite;
  logic [N_PORTS*3-1:0]      req_hsize;
  logic [N_PORTS*4-1:0]      req_hprot;
  logic [N_PORTS*W_DATA-1:0] req_wdata;
  logic [W_DATA-1:0]         req_rdata;

  logic [W_ADDR-1:0]         ahblm_haddr;
  logic                      ahblm_hwrite;
  logic [1:0]                ahblm_htrans;
  logic [2:0]                ahblm_hsize;
  logic [2:0]                ahblm_hburst;
  logic [3:0]                ahblm_hprot;
  logic                      ahblm_hmastlock;
  logic                      ahblm_hready;
  logic                      ahblm_hresp;
  logic [W_DATA-1:0]         ahblm_hwdata;
  logic [W_DATA-1:0]         ahblm_hrdata;

  // Environment view: requesters plus the fabric.
  modport master (
    output req_aph_req, req_aph_urgent, req_haddr, req_hwrite, req_hsize, req_hprot, req_wdata,
    output ahblm_hready, ahblm_hresp, ahblm_hrdata,
    input  req_aph_ready, req_dph_ready, req_dph_err, req_rdata,
    input  ahblm_haddr, ahblm_hwrite, ahblm_htrans, ahblm_hsize, ahblm_hburst, ahblm_hprot,
    input  ahblm_hmastlock, ahblm_hwdata
  );

  // Arbiter view.
  modport slave (
    input  req_aph_req, req_aph_urgent, req_haddr, req_hwrite, req_hsize, req_hprot, req_wdata,
    input  ahblm_hready, ahblm_hresp, ahblm_hrdata,
    output req_aph_ready, req_dph_ready, req_dph_err, req_rdata,
    output ahblm_haddr, ahblm_hwrite, ahblm_htrans, ahblm_hsize, ahblm_hburst, ahblm_hprot,
    output ahblm_hmastlock, ahblm_hwdata
  );
endinterface

// File: rtl/hazard3_rr_pick.sv
// Combinational round-robin picker: one-hot grant to the first request at or after ptr,
// wrapping N-1 -> 0; zero when nothing requests.
module hazard3_rr_pick #(
  parameter int N     = 2,
  parameter int W_PTR = 1
) (
  input  logic [N-1:0]     req,
  input  logic [W_PTR-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic found;

  // Pass p examines the port p places after ptr; constant j keeps the selects static.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int p = 0; p < N; p++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && req[j] && (j == (int'(ptr) + p) % N)) begin
          gnt[j] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hazard3_bus_arbiter.sv
// N-way round-robin arbiter with urgent override, sharing one AHB-Lite master port
// among split-phase requesters; a stalled address phase keeps its owner until accepted.
module hazard3_bus_arbiter
  import hazard3_ahbl_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int W_ADDR  = 32,
  parameter int W_DATA  = 32
) (
  input logic                 clk,
  input logic                 rst,
  hazard3_bus_arbiter_if.slave bus
);

  localparam int W_PTR = ptr_width(N_PORTS);
  localparam logic [N_PORTS-1:0] ONE = N_PORTS'(1);

  logic               hold;
  logic               urg_prev;
  logic [N_PORTS-1:0] gnt_prev;
  logic [N_PORTS-1:0] dph_owner;
  logic [W_PTR-1:0]   rr_ptr;

  logic [N_PORTS-1:0] gnt;
  logic [N_PORTS-1:0] rr_gnt;
  logic [N_PORTS-1:0] urg_req;
  logic [N_PORTS-1:0] dph_live;
  logic               urg_path;
  logic [W_PTR-1:0]   rr_ptr_nxt;

  hazard3_rr_pick #(.N(N_PORTS), .W_PTR(W_PTR)) u_pick (
    .req (bus.req_aph_req),
    .ptr (rr_ptr),
    .gnt (rr_gnt)
  );

  assign urg_req  = bus.req_aph_req & bus.req_aph_urgent;
  assign dph_live = rst ? '0 : dph_owner;

  // urg_prev remembers how a held grant was won, so its eventual accept
  // advances the pointer only for round-robin wins.
  always_comb begin
    gnt      = '0;
    urg_path = 1'b0;
    if (rst) begin
      gnt = '0;
    end else if (hold) begin
      gnt      = gnt_prev;
      urg_path = urg_prev;
    end else if (|urg_req) begin
      gnt      = urg_req & (~urg_req + ONE);
      urg_path = 1'b1;
    end else begin
      gnt = rr_gnt;
    end
  end

  always_comb begin
    bus.ahblm_haddr  = '0;
    bus.ahblm_hwrite = 1'b0;
    bus.ahblm_hsize  = 3'b000;
    bus.ahblm_hprot  = 4'b0000;
    bus.ahblm_hwdata = '0;
    rr_ptr_nxt       = rr_ptr;
    for (int k = 0; k < N_PORTS; k++) begin
      if (gnt[k]) begin
        bus.ahblm_haddr  = bus.req_haddr[k*W_ADDR +: W_ADDR];
        bus.ahblm_hwrite = bus.req_hwrite[k];
        bus.ahblm_hsize  = bus.req_hsize[k*3 +: 3];
        bus.ahblm_hprot  = bus.req_hprot[k*4 +: 4];
        if (bus.ahblm_hready && !urg_path)
          rr_ptr_nxt = W_PTR'((k + 1) % N_PORTS);
      end
      if (dph_live[k])
        bus.ahblm_hwdata = bus.req_wdata[k*W_DATA +: W_DATA];
    end
  end

  assign bus.ahblm_htrans    = (|gnt) ? HTRANS_NSEQ : HTRANS_IDLE;
  assign bus.ahblm_hburst    = HBURST_SINGLE;
  assign bus.ahblm_hmastlock = 1'b0;
  assign bus.req_aph_ready   = {N_PORTS{bus.ahblm_hready}} & gnt;
  assign bus.req_dph_ready   = {N_PORTS{bus.ahblm_hready}} & dph_live;
  assign bus.req_dph_err     = {N_PORTS{bus.ahblm_hready & bus.ahblm_hresp}} & dph_live;
  assign bus.req_rdata       = bus.ahblm_hrdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold      <= 1'b0;
      urg_prev  <= 1'b0;
      gnt_prev  <= '0;
      dph_owner <= '0;
      rr_ptr    <= '0;
    end else begin
      hold     <= bus.ahblm_htrans[1] && !bus.ahblm_hready;
      urg_prev <= urg_path;
      gnt_prev <= gnt;
      rr_ptr   <= rr_ptr_nxt;
      if (bus.ahblm_hready)
        dph_owner <= gnt;
    end
  end

endmodule

// File: doc/hazard3_bus_arbiter.md
Name: hazard3_bus_arbiter

Overview:
- N-way arbiter that shares one AHB-Lite master port between N requesters using the core's split-phase handshake: aph_req/aph_ready, then dph_ready/dph_err.
- Generalises the fixed two-port instr/data arbitration to configurable N.
- Scheduling is round-robin, with a per-port urgent override.
- Sits between hazard3_core instances (or core plus DMA/debug masters) and the system AHB-Lite fabric.

Parameters:
N_PORTS, 2, number of requesters (2..8)
W_ADDR, 32, address width
W_DATA, 32, data width
W_PTR, $clog2(N_PORTS) (minimum 1), width of round-robin pointer (localparam)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
req_aph_req  input  N_PORTS  per-port address-phase request
req_aph_urgent  input  N_PORTS  per-port urgent flag (like fetch panic); qualified by aph_req
req_aph_ready  output  N_PORTS  address phase accepted this cycle
req_dph_ready  output  N_PORTS  data phase completes this cycle
req_dph_err  output  N_PORTS  data phase completed with error
req_haddr  input  N_PORTS*W_ADDR  packed per-port address
req_hwrite  input  N_PORTS  per-port write flag
req_hsize  input  N_PORTS*3  per-port size
req_hprot  input  N_PORTS*4  per-port protection
req_wdata  input  N_PORTS*W_DATA  per-port write data (data-phase timing)
req_rdata  output  W_DATA  shared read data (hrdata broadcast)
ahblm_haddr  output  W_ADDR  AHB address
ahblm_hwrite  output  1  AHB write
ahblm_htrans  output  2  AHB trans (IDLE/NSEQ only)
ahblm_hsize  output  3  AHB size
ahblm_hburst  output  3  tied SINGLE (3'b000)
ahblm_hprot  output  4  AHB prot
ahblm_hmastlock  output  1  tied 0
ahblm_hready  input  1  AHB ready
ahblm_hresp  input  1  AHB error response
ahblm_hwdata  output  W_DATA  write data of the port in data phase
ahblm_hrdata  input  W_DATA  AHB read data

Behaviour:
- Registers:
  - hold (1b): grant frozen.
  - gnt_prev (N one-hot): last cycle's grant.
  - dph_owner (N one-hot): port in data phase.
  - rr_ptr (W_PTR): port with highest round-robin priority.
- Reset (rst high at posedge):
  - hold=0, gnt_prev=0, dph_owner=0, rr_ptr=0.
  - All outputs derive combinationally, so in reset: htrans=IDLE, haddr/hsize/hprot/hwrite=0, all req_* ready/err=0, hwdata=0.
- Grant (combinational, one-hot or zero):
  - hold=1 -> gnt=gnt_prev.
  - Else any port with aph_req&urgent -> lowest-index such port.
  - Else any aph_req -> first requesting port at or after rr_ptr, scanning upward and wrapping N-1 -> 0.
  - Else gnt=0.
- hold update: hold <= htrans[1] && !hready. A stalled address phase keeps its owner until accepted; urgent cannot pre-empt it.
- Requester obligation: a port must keep aph_req and address signals stable until aph_ready. If a port withdraws during hold, the arbiter still issues its stale signals. This is a protocol violation; the bench asserts on it.
- AHB mux:
  - gnt nonzero -> htrans=NSEQ with the granted port's haddr/hwrite/hsize/hprot.
  - Else IDLE with all fields 0.
- Handshake:
  - req_aph_ready[k] = hready & gnt[k].
  - req_dph_ready[k] = hready & dph_owner[k].
  - req_dph_err[k] = hready & dph_owner[k] & hresp.
  - Error is signalled only on the final (hready=1) cycle of a two-cycle error response.
- dph_owner <= gnt when hready, else it holds. Data phase may overlap the next address phase; latency is 1 cycle minimum from aph accept to dph_ready.
- ahblm_hwdata = wdata of dph_owner, 0 if none. req_rdata = hrdata, unqualified.
- rr_ptr update: on hready & gnt[k] with the grant not won via the urgent path, rr_ptr <= (k+1) mod N_PORTS. An urgent grant leaves rr_ptr unchanged.
- Simultaneous events:
  - Accept and new request in the same cycle is legal; back-to-back NSEQ from different ports is allowed.
  - The same port may be re-granted the next cycle only if no other port requests, or if it is urgent.
- Non-power-of-two N_PORTS: the pointer wraps at N_PORTS-1, never reaching unused codes.
- Reset mid-transfer: the outstanding data phase is abandoned; no dph_ready is issued after reset. The fabric is reset with the arbiter.

Decomposition:
- Package hazard3_ahbl_pkg: HTRANS_IDLE=2'b00, HTRANS_NSEQ=2'b10, HBURST_SINGLE=3'b000, HPROT_DATA=4'b0011, HPROT_INSTR=4'b0010.
- Sub-module hazard3_rr_pick: combinational N-wide round-robin one-hot picker. Inputs req and ptr; outputs gnt. Reusable and unit-tested separately.

Test Plan:
- N=3, ports 0,1,2 all request continuously, hready=1 -> grants 0,1,2,0,1,2 on consecutive cycles; each dph_ready exactly 1 cycle after its aph_ready.
- Port 1 granted, hready low 3 cycles while port 0 asserts urgent -> haddr stays port 1's address (e.g. 0x2000_0010) for all 4 cycles; port 0 granted the cycle after acceptance; rr_ptr unchanged by the urgent grant.
- Port 2 write 0x1234_5678 to 0x4000_0000, then port 0 read issued back-to-back -> hwdata=0x1234_5678 in the cycle port 0's address is on the bus; port 0 sees dph_ready the next cycle.
- Two-cycle error response on port 1's data phase (hresp=1, hready 0 then 1) -> req_dph_err[1]=1 only on the hready=1 cycle; other ports' err stay 0.
- rst asserted while port 0's data phase is stalled -> next cycle htrans=IDLE, dph_owner=0, all ready/err 0, rr_ptr=0; after release, port 0 is granted first.
- No requests for 10 cycles -> htrans=IDLE, haddr=0, hwdata=0, hold never set.
